ascon_arbiter: RTL

- Shares one ascon core between NREQ requesters, each presenting a full job configuration: key, nonce, AD size, PT size and delay.
- Round-robin arbitration. The block registers the winner's configuration, starts the core, and watches it to completion.
- Captures the tag, returns it to the winner with a done pulse, and flags a watchdog timeout.
- AD/PT/CT FIFO data muxing sits outside this block and is steered by gnt_o.

---
 rtl/ascon_arbiter_pkg.sv | 21 ++
 rtl/ascon_arbiter_counter.sv | 28 ++
 rtl/ascon_arbiter_rr.sv | 36 +++
 rtl/ascon_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ascon_arbiter_pkg.sv
// Shared types and constants for the ascon job arbiter.
package ascon_arbiter_pkg;

    typedef logic [127:0] u128_t;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        BUSY,
        DONE
    } arb_state_e;

    localparam int NREQ_MAX = 8;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ascon_arbiter_counter.sv
// Saturating up-counter with synchronous load; load has priority over count.
module counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;

    // Load, else count up and stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= load_val_i;
        end else if (en_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/ascon_arbiter_rr.sv
// Combinational round-robin pick: first request at index >= ptr_i, wrapping.
module rr_arbiter
    import ascon_arbiter_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);

    logic [NREQ-1:0] w_hi;
    logic [NREQ-1:0] w_pick;

    // Prefer requests at or above the pointer; fall back to the full vector
    // for the wrap-around case, then take the lowest set bit.
    always_comb begin
        w_hi = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_hi[i] = req_i[i] && (IW'(i) >= ptr_i);
        end
        w_pick = (|w_hi) ? w_hi : req_i;
        gnt_o  = '0;
        idx_o  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_pick[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = IW'(i);
            end
        end
    end

endmodule

// File: rtl/ascon_arbiter.sv
// Shares one ascon core between NREQ requesters: round-robin grant, config
// capture, start handshake, tag return and watchdog timeout.
module ascon_arbiter
    import ascon_arbiter_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int DATA_AW     = 7,
    parameter int DELAY_WIDTH = 16,
    parameter int WDOG_WIDTH  = 12
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NREQ-1:0]                  req_i,
    input  logic [NREQ-1:0][127:0]           key_i,
    input  logic [NREQ-1:0][127:0]           nonce_i,
    input  logic [NREQ-1:0][DATA_AW-1:0]     ad_size_i,
    input  logic [NREQ-1:0][DATA_AW-1:0]     pt_size_i,
    input  logic [NREQ-1:0][DELAY_WIDTH-1:0] delay_i,
    output logic [NREQ-1:0]                  gnt_o,
    output logic [NREQ-1:0]                  done_o,
    output logic [NREQ-1:0]                  err_o,
    output logic [127:0]                     tag_o,
    output logic [127:0]                     core_key_o,
    output logic [127:0]                     core_nonce_o,
    output logic [DATA_AW-1:0]               core_ad_size_o,
    output logic [DATA_AW-1:0]               core_pt_size_o,
    output logic [DELAY_WIDTH-1:0]           core_delay_o,
    output logic                             core_start_o,
    input  logic                             core_ready_i,
    input  logic                             core_tag_valid_i,
    input  logic [127:0]                     core_tag_i
);

    localparam int IW = idx_w(NREQ);

    arb_state_e              r_state;
    logic [IW-1:0]           r_rr;
    logic [IW-1:0]           r_win;
    logic [NREQ-1:0]         r_gnt;
    logic [NREQ-1:0]         r_done;
    logic [NREQ-1:0]         r_err;
    u128_t                   r_tag;
    u128_t                   r_key;
    u128_t                   r_nonce;
    logic [DATA_AW-1:0]      r_ad_size;
    logic [DATA_AW-1:0]      r_pt_size;
    logic [DELAY_WIDTH-1:0]  r_delay;
    logic                    r_start;

    logic [NREQ-1:0]         w_arb_gnt;
    logic [IW-1:0]           w_arb_idx;
    logic [WDOG_WIDTH-1:0]   w_wdog;
    logic                    w_wdog_clr;
    logic                    w_wdog_en;
    logic                    w_wdog_max;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req_i (req_i),
        .ptr_i (r_rr),
        .gnt_o (w_arb_gnt),
        .idx_o (w_arb_idx)
    );

    // Watchdog counts while the core owns the job, cleared around each job.
    assign w_wdog_clr = (r_state == GRANT) || (r_state == DONE);
    assign w_wdog_en  = (r_state == START) || (r_state == BUSY);
    assign w_wdog_max = (w_wdog == '1);

    counter #(
        .W (WDOG_WIDTH)
    ) u_wdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_wdog_clr),
        .load_val_i ('0),
        .en_i       (w_wdog_en),
        .cnt_o      (w_wdog)
    );

    // Job sequencer; every output is a register so done/err land exactly in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rr      <= '0;
            r_win     <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_tag     <= '0;
            r_key     <= '0;
            r_nonce   <= '0;
            r_ad_size <= '0;
            r_pt_size <= '0;
            r_delay   <= '0;
            r_start   <= 1'b0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                IDLE: begin
                    // Config is latched with the grant so requesters may move on
                    // as soon as they see gnt_o.
                    if (core_ready_i && (|req_i)) begin
                        r_win     <= w_arb_idx;
                        r_gnt     <= w_arb_gnt;
                        r_key     <= key_i[w_arb_idx];
                        r_nonce   <= nonce_i[w_arb_idx];
                        r_ad_size <= ad_size_i[w_arb_idx];
                        r_pt_size <= pt_size_i[w_arb_idx];
                        r_delay   <= delay_i[w_arb_idx];
                        r_state   <= GRANT;
                    end
                end
                GRANT: begin
                    r_start <= 1'b1;
                    r_state <= START;
                end
                START: begin
                    if (!core_ready_i) begin
                        r_start <= 1'b0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    // A tag arriving on the timeout cycle still counts as success.
                    if (core_tag_valid_i) begin
                        r_tag   <= core_tag_i;
                        r_done  <= r_gnt;
                        r_state <= DONE;
                    end else if (w_wdog_max) begin
                        r_done  <= r_gnt;
                        r_err   <= r_gnt;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_gnt   <= '0;
                    r_rr    <= (r_win == IW'(NREQ - 1)) ? '0 : r_win + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt_o          = r_gnt;
    assign done_o         = r_done;
    assign err_o          = r_err;
    assign tag_o          = r_tag;
    assign core_key_o     = r_key;
    assign core_nonce_o   = r_nonce;
    assign core_ad_size_o = r_ad_size;
    assign core_pt_size_o = r_pt_size;
    assign core_delay_o   = r_delay;
    assign core_start_o   = r_start;

endmodule
